// File: rtl/lock_chamber_model.sv
`default_nettype none
// ============================================================================
//  Module      : lock_chamber_model
//  Description : Behavioural responder for the canal-lock controller. Accepts
//                equalize commands over valid/ready, ramps the chamber level
//                one STEP per slow tick, settles, then pulses done.
//                Optional per-command tick timeout: define LOCK_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_chamber_model #(
    parameter int WIDTH         = 8,
    parameter int STEP          = 4,
    parameter int RESET_LEVEL   = 0,
    parameter int SETTLE_TICKS  = 3,
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             req_valid,
    input  logic [1:0]       req_cmd,
    output logic             req_ready,
    input  logic [WIDTH-1:0] outer_level,
    input  logic [WIDTH-1:0] inner_level,
    input  logic             abort,
    output logic [WIDTH-1:0] lock_level,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    localparam int c_settle_w = $clog2(SETTLE_TICKS + 1);

    localparam logic [WIDTH-1:0]      c_step        = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]      c_reset_level = WIDTH'(RESET_LEVEL);
    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_TICKS);
    localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_ramp   = 2'd1;
    localparam logic [1:0] c_st_settle = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [1:0] c_cmd_outer = 2'b01;
    localparam logic [1:0] c_cmd_inner = 2'b10;

    // Reject parameter sets that would break the snap/settle arithmetic.
    if (STEP < 1 || STEP >= (1 << WIDTH) || SETTLE_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("lock_chamber_model: illegal parameter set");
    end

    logic [1:0]            r_state;
    logic [WIDTH-1:0]      r_level;
    logic [WIDTH-1:0]      r_target;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic                  r_cmd_err;

    logic [1:0]            w_state_nxt;
    logic [WIDTH-1:0]      w_level_nxt;
    logic [WIDTH-1:0]      w_target_nxt;
    logic [c_settle_w-1:0] w_settle_nxt;
    logic                  w_cmd_err_nxt;

    logic                  w_accept;
    logic                  w_up;
    logic [WIDTH-1:0]      w_diff;
    logic                  w_snap;
    logic [WIDTH-1:0]      w_ramp_level;
    logic [WIDTH-1:0]      w_cmd_target;

`ifdef LOCK_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_to_w-1:0] c_timeout = c_to_w'(TIMEOUT_TICKS);

    logic [c_to_w-1:0] r_tick_cnt;
    logic [c_to_w-1:0] w_tick_nxt;
`endif

    assign w_accept = req_valid && (r_state == c_st_idle);

    // Distance to target and the next ramp level; the snap keeps unsigned
    // arithmetic from overshooting or wrapping at either rail.
    always_comb begin
        w_up         = r_target > r_level;
        w_diff       = w_up ? (r_target - r_level) : (r_level - r_target);
        w_snap       = w_diff <= c_step;
        w_ramp_level = w_snap ? r_target : (w_up ? (r_level + c_step) : (r_level - c_step));
        w_cmd_target = (req_cmd == c_cmd_outer) ? outer_level : inner_level;
    end

    // Next-state and next-data decode; abort outranks a coincident tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_target_nxt  = r_target;
        w_settle_nxt  = r_settle_cnt;
        w_cmd_err_nxt = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (req_cmd == c_cmd_outer || req_cmd == c_cmd_inner) begin
                        w_target_nxt = w_cmd_target;
                        if (w_cmd_target != r_level) begin
                            w_state_nxt = c_st_ramp;
                        end else begin
                            w_state_nxt  = c_st_settle;
                            w_settle_nxt = c_settle_load;
                        end
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end
            c_st_ramp: begin
                if (abort) begin
                    w_state_nxt = c_st_idle;
                end else if (tick) begin
                    w_level_nxt = w_ramp_level;
                    if (w_snap) begin
                        w_state_nxt  = c_st_settle;
                        w_settle_nxt = c_settle_load;
                    end
                end
            end
            c_st_settle: begin
                if (abort) begin
                    w_state_nxt = c_st_idle;
                end else if (tick) begin
                    w_settle_nxt = r_settle_cnt - c_settle_one;
                    if (r_settle_cnt == c_settle_one) begin
                        w_state_nxt = c_st_done;
                    end
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

`ifdef LOCK_TIMEOUT_EN
        // Ticks spent on the active command; the limit wins over everything.
        w_tick_nxt = r_tick_cnt;
        if (w_accept) begin
            w_tick_nxt = '0;
        end else if (tick && (r_state == c_st_ramp || r_state == c_st_settle)) begin
            w_tick_nxt = r_tick_cnt + c_to_w'(1);
            if (w_tick_nxt == c_timeout) begin
                w_state_nxt   = c_st_idle;
                w_cmd_err_nxt = 1'b1;
            end
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_level      <= c_reset_level;
            r_target     <= '0;
            r_settle_cnt <= '0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_target     <= w_target_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
        end
    end

`ifdef LOCK_TIMEOUT_EN
    // Per-command tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick_nxt;
        end
    end
`endif

    assign req_ready  = (r_state == c_st_idle);
    assign busy       = (r_state == c_st_ramp) || (r_state == c_st_settle);
    assign done       = (r_state == c_st_done);
    assign cmd_err    = r_cmd_err;
    assign lock_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_lock_chamber_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_chamber_model
//  Description : Self-checking bench for lock_chamber_model (default build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_chamber_model;

    localparam int WIDTH  = 8;
    localparam int STEP   = 4;
    localparam int SETTLE = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0;
    logic             req_valid = 1'b0;
    logic [1:0]       req_cmd = 2'b00;
    logic             req_ready;
    logic [WIDTH-1:0] outer_level = '0;
    logic [WIDTH-1:0] inner_level = '0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] lock_level;
    logic             busy;
    logic             done;
    logic             cmd_err;

    int total = 0;
    int bad   = 0;
    int m_level = 0;

    lock_chamber_model #(
        .WIDTH(WIDTH), .STEP(STEP), .RESET_LEVEL(0),
        .SETTLE_TICKS(SETTLE), .TIMEOUT_TICKS(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .outer_level(outer_level), .inner_level(inner_level), .abort(abort),
        .lock_level(lock_level), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // One accept cycle, then scramble level inputs so later changes are exercised.
    task automatic send(input logic [1:0] cmd, input logic [7:0] o, input logic [7:0] i);
        req_valid = 1'b1; req_cmd = cmd; outer_level = o; inner_level = i;
        cyc();
        req_valid = 1'b0; req_cmd = 2'($urandom);
        outer_level = 8'($urandom); inner_level = 8'($urandom);
    endtask

    // Random idle gap, then a single tick; outputs are observed right after it.
    task automatic do_tick();
        idle($urandom_range(0, 2));
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // Chamber level expected after k ticks of ramping from s toward t.
    function automatic int traj(input int s, input int t, input int k);
        int d;
        d = (t > s) ? t - s : s - t;
        if (k * STEP >= d) return t;
        return (t > s) ? s + k * STEP : s - k * STEP;
    endfunction

    task automatic test_reset();
        outer_level = 8'd77; inner_level = 8'd33; req_valid = 1'b1; req_cmd = 2'b01;
        idle(2);
        total++; if (lock_level !== 8'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", lock_level); end
        total++; if ({req_ready, busy, done, cmd_err} !== 4'b1000) begin bad++; $display("FAIL reset_flags got=%b want=1000", {req_ready, busy, done, cmd_err}); end
        req_valid = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) do_tick();
        total++; if (lock_level !== 8'd0 || req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_ticks level=%0d ready=%b busy=%b want 0/1/0", lock_level, req_ready, busy); end
        m_level = 0;
    endtask

    task automatic test_fill();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'd4; exp_seq[1] = 8'd8; exp_seq[2] = 8'd10;
        send(2'b01, 8'd10, 8'd200);
        total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL fill_accept busy=%b ready=%b want 1/0", busy, req_ready); end
        for (int k = 0; k < 3; k++) begin
            do_tick();
            total++; if (lock_level !== exp_seq[k]) begin bad++; $display("FAIL fill_level k=%0d got=%0d want=%0d", k, lock_level, exp_seq[k]); end
        end
        for (int s = 1; s <= SETTLE; s++) begin
            do_tick();
            total++; if (done !== (s == SETTLE)) begin bad++; $display("FAIL fill_done s=%0d got=%b want=%b", s, done, s == SETTLE); end
        end
        cyc();
        total++; if (done !== 1'b0 || req_ready !== 1'b1 || lock_level !== 8'd10) begin bad++; $display("FAIL fill_after done=%b ready=%b level=%0d want 0/1/10", done, req_ready, lock_level); end
        m_level = 10;
    endtask

    task automatic test_drain();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'd6; exp_seq[1] = 8'd2; exp_seq[2] = 8'd1;
        send(2'b10, 8'd250, 8'd1);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            total++; if (lock_level !== exp_seq[k]) begin bad++; $display("FAIL drain_level k=%0d got=%0d want=%0d", k, lock_level, exp_seq[k]); end
        end
        for (int s = 1; s <= SETTLE; s++) begin
            do_tick();
            total++; if (lock_level !== 8'd1 || done !== (s == SETTLE)) begin bad++; $display("FAIL drain_settle s=%0d level=%0d done=%b want 1/%b", s, lock_level, done, s == SETTLE); end
        end
        cyc();
        m_level = 1;
    endtask

    task automatic test_equal_and_illegal();
        send(2'b01, 8'd1, 8'd90);
        total++; if (busy !== 1'b1 || lock_level !== 8'd1) begin bad++; $display("FAIL equal_accept busy=%b level=%0d want 1/1", busy, lock_level); end
        for (int s = 1; s <= SETTLE; s++) begin
            do_tick();
            total++; if (lock_level !== 8'd1 || done !== (s == SETTLE)) begin bad++; $display("FAIL equal_settle s=%0d level=%0d done=%b", s, lock_level, done); end
        end
        cyc();
        send(2'b11, 8'd50, 8'd60);
        total++; if (cmd_err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL illegal11 err=%b ready=%b busy=%b want 1/1/0", cmd_err, req_ready, busy); end
        cyc();
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b want=0", cmd_err); end
        send(2'b00, 8'd50, 8'd60);
        total++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL illegal00 err=%b busy=%b want 1/0", cmd_err, busy); end
        do_tick(); do_tick();
        total++; if (lock_level !== 8'd1 || busy !== 1'b0) begin bad++; $display("FAIL illegal_level got=%0d want=1", lock_level); end
    endtask

    task automatic test_reset_midop();
        send(2'b01, 8'd100, 8'd0);
        do_tick(); do_tick();
        #2 rst_n = 1'b0;
        #1;
        total++; if (lock_level !== 8'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL midop_reset level=%0d busy=%b ready=%b want 0/0/1", lock_level, busy, req_ready); end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_tick();
            total++; if (done !== 1'b0 || lock_level !== 8'd0) begin bad++; $display("FAIL midop_quiet done=%b level=%0d want 0/0", done, lock_level); end
        end
        m_level = 0;
    endtask

    task automatic test_abort();
        send(2'b01, 8'd200, 8'd0);
        for (int k = 0; k < 5; k++) do_tick();
        abort = 1'b1; cyc(); abort = 1'b0;
        total++; if (lock_level !== 8'd20 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_ramp level=%0d ready=%b busy=%b done=%b want 20/1/0/0", lock_level, req_ready, busy, done); end
        for (int k = 0; k < 4; k++) do_tick();
        total++; if (lock_level !== 8'd20 || done !== 1'b0) begin bad++; $display("FAIL abort_frozen level=%0d done=%b want 20/0", lock_level, done); end
        send(2'b10, 8'd0, 8'd0);
        do_tick(); do_tick();
        abort = 1'b1; tick = 1'b1; cyc(); abort = 1'b0; tick = 1'b0;
        total++; if (lock_level !== 8'd12 || req_ready !== 1'b1) begin bad++; $display("FAIL abort_tick level=%0d ready=%b want 12/1", lock_level, req_ready); end
        do_tick();
        total++; if (lock_level !== 8'd12 || done !== 1'b0) begin bad++; $display("FAIL abort_tick_after level=%0d done=%b want 12/0", lock_level, done); end
        m_level = 12;
    endtask

    // Random command stream, back to back, with random aborts and equal targets.
    task automatic test_random_sequence();
        for (int it = 0; it < 40; it++) begin
            int cmd, tgt, n, tot, abort_k, s;
            cmd = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 3) : $urandom_range(1, 2);
            tgt = ($urandom_range(0, 5) == 0) ? m_level : $urandom_range(0, 255);
            s = m_level;
            if (cmd == 0 || cmd == 3) begin
                send(2'(cmd), 8'($urandom), 8'($urandom));
                total++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rnd_illegal it=%0d err=%b busy=%b want 1/0", it, cmd_err, busy); end
                do_tick();
                total++; if (lock_level !== 8'(s)) begin bad++; $display("FAIL rnd_illegal_level it=%0d got=%0d want=%0d", it, lock_level, s); end
                continue;
            end
            if (cmd == 1) send(2'b01, 8'(tgt), 8'($urandom));
            else          send(2'b10, 8'($urandom), 8'(tgt));
            n   = ((tgt > s ? tgt - s : s - tgt) + STEP - 1) / STEP;
            tot = n + SETTLE;
            abort_k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tot - 1) : -1;
            for (int k = 1; k <= tot; k++) begin
                if (k - 1 == abort_k) begin
                    abort = 1'b1; tick = 1'($urandom_range(0, 1)); cyc(); abort = 1'b0; tick = 1'b0;
                    total++; if (lock_level !== 8'(traj(s, tgt, k - 1)) || req_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rnd_abort it=%0d level=%0d want=%0d ready=%b done=%b", it, lock_level, traj(s, tgt, k - 1), req_ready, done); end
                    m_level = traj(s, tgt, k - 1);
                    break;
                end
                do_tick();
                total++; if (lock_level !== 8'(traj(s, tgt, k)) || done !== (k == tot)) begin bad++; $display("FAIL rnd_step it=%0d k=%0d level=%0d want=%0d done=%b", it, k, lock_level, traj(s, tgt, k), done); end
                if (k == tot) begin
                    cyc();
                    total++; if (req_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rnd_ready it=%0d ready=%b done=%b want 1/0", it, req_ready, done); end
                    m_level = tgt;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_equal_and_illegal();
        test_reset_midop();
        test_abort();
        test_random_sequence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
